// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg: state encoding and default field widths shared by the pulse scheduler.
package pulse_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;
  localparam int CW_DEF = 8;
  localparam int NW_DEF = 4;
endpackage

// File: rtl/pulse_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; pointer names the favoured requester and moves past each winner.
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1,
  output logic pointer
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt0 = req0 & (~req1 | ~ptr_q);
    gnt1 = req1 & (~req0 | ptr_q);
    ptr_d = advance ? gnt0 : ptr_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
  assign pointer = ptr_q;
endmodule

// File: rtl/pulse_sched.sv
// pulse_sched: shares one pulse line between two requesters, sequencing n pulses of hi high / lo low cycles.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic [CW-1:0] hi0,
  input  logic [CW-1:0] lo0,
  input  logic [NW-1:0] n0,
  input  logic          req1,
  input  logic [CW-1:0] hi1,
  input  logic [CW-1:0] lo1,
  input  logic [NW-1:0] n1,
  output logic          ack0,
  output logic          ack1,
  output logic          done0,
  output logic          done1,
  output logic          busy,
  output logic          owner,
  output logic          signal
);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d, hi_sel, lo_sel;
  logic [NW-1:0] pulses_q, pulses_d, n_sel;
  logic sig_q, sig_d, busy_q, busy_d, owner_q, owner_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d, done0_q, done0_d, done1_q, done1_d;
  logic advance, gnt0, gnt1, win, pointer;
  assign advance = (state_q == IDLE) & (req0 | req1);
  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .advance(advance),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .pointer(pointer)
  );
  assign win    = gnt1;
  assign hi_sel = win ? hi1 : hi0;
  assign lo_sel = win ? lo1 : lo0;
  assign n_sel  = win ? n1 : n0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    owner_d  = owner_q;
    sig_d    = sig_q;
    busy_d   = busy_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (advance) begin
          owner_d = win;
          ack0_d  = ~win;
          ack1_d  = win;
          // Zero-length phases behave as one cycle so every pulse is visible.
          hi_d = (hi_sel == '0) ? CW'(1) : hi_sel;
          lo_d = (lo_sel == '0) ? CW'(1) : lo_sel;
          if (n_sel == '0) begin
            done0_d = ~win;
            done1_d = win;
          end else begin
            state_d  = HIGH;
            sig_d    = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = hi_d - CW'(1);
            pulses_d = n_sel;
          end
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          sig_d   = 1'b0;
          cnt_d   = lo_q - CW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (pulses_q == NW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else begin
          state_d  = HIGH;
          sig_d    = 1'b1;
          cnt_d    = hi_q - CW'(1);
          pulses_d = pulses_q - NW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sig_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pulses_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      owner_q  <= 1'b0;
      sig_q    <= 1'b0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulses_q <= pulses_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      owner_q  <= owner_d;
      sig_q    <= sig_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign busy   = busy_q;
  assign owner  = owner_q;
  assign signal = sig_q;
endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: directed checks of grant, waveform, fairness, clamping, reset abort and config latching.
module tb_pulse_sched;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [7:0] hi0 = '0, lo0 = '0, hi1 = '0, lo1 = '0;
  logic [3:0] n0 = '0, n1 = '0;
  logic ack0, ack1, done0, done1, busy, owner, signal;
  int n_run = 0;
  int n_fail = 0;
  pulse_sched #(.CW(8), .NW(4)) dut (
    .clock (clock),
    .reset (reset),
    .req0  (req0),
    .hi0   (hi0),
    .lo0   (lo0),
    .n0    (n0),
    .req1  (req1),
    .hi1   (hi1),
    .lo1   (lo1),
    .n1    (n1),
    .ack0  (ack0),
    .ack1  (ack1),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .owner (owner),
    .signal(signal)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  // Grant happens at the next edge; pat holds the expected signal per cycle, bit 0 first.
  task automatic train(input bit who, input logic [31:0] pat, input int len, input bit drop);
    for (int i = 0; i < len; i++) begin
      step();
      if (i == 0) begin
        check("ack", who ? ack1 : ack0, 1);
        check("owner", owner, who);
        if (drop) begin
          if (who) req1 = 1'b0;
          else req0 = 1'b0;
        end
      end
      check("signal", signal, pat[i]);
      check("busy", busy, 1);
      check("other_ack", who ? ack0 : ack1, 0);
      check("early_done", done0 | done1, 0);
    end
    step();
    check("busy_end", busy, 0);
    check("signal_end", signal, 0);
    check("done", who ? done1 : done0, 1);
    check("other_done", who ? done0 : done1, 0);
  endtask
  initial begin
    step();
    step();
    check("rst_outs", {signal, busy, ack0, ack1, done0, done1, owner}, 0);
    reset = 1'b1;
    req0 = 1'b1; hi0 = 8'd3; lo0 = 8'd2; n0 = 4'd2;
    train(1'b0, 32'b0011100111, 10, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    hi0 = 8'd1; lo0 = 8'd1; n0 = 4'd1;
    hi1 = 8'd1; lo1 = 8'd1; n1 = 4'd1;
    req0 = 1'b1; req1 = 1'b1;
    train(1'b0, 32'b01, 2, 1'b0);
    train(1'b1, 32'b01, 2, 1'b0);
    train(1'b0, 32'b01, 2, 1'b0);
    train(1'b1, 32'b01, 2, 1'b1);
    req0 = 1'b0;
    step();
    check("idle_gap", {ack0, ack1, busy}, 0);
    req1 = 1'b1; n1 = 4'd0; hi1 = 8'd5;
    step();
    check("zero_n_ack", ack1, 1);
    check("zero_n_done", done1, 1);
    check("zero_n_quiet", {signal, busy, ack0, done0}, 0);
    req1 = 1'b0;
    req0 = 1'b1; hi0 = 8'd0; lo0 = 8'd0; n0 = 4'd3;
    train(1'b0, 32'b010101, 6, 1'b1);
    req0 = 1'b1; hi0 = 8'd4; lo0 = 8'd4; n0 = 4'd2;
    step();
    check("abort_ack", ack0, 1);
    req0 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("abort_hi1", signal, 1);
    step();
    check("abort_hi2", {signal, busy}, 2'b11);
    reset = 1'b0;
    step();
    check("abort_outs", {signal, busy, done0, done1}, 0);
    step();
    check("abort_nodone", done0, 0);
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    step();
    check("post_rst_ack0", ack0, 1);
    check("post_rst_ack1", ack1, 0);
    check("post_rst_owner", owner, 0);
    req0 = 1'b0; req1 = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    req0 = 1'b1; hi0 = 8'd2; lo0 = 8'd2; n0 = 4'd1;
    step();
    check("cfg_ack", ack0, 1);
    check("cfg_s0", signal, 1);
    req0 = 1'b0; hi0 = 8'd7;
    step();
    check("cfg_s1", signal, 1);
    step();
    check("cfg_s2", signal, 0);
    step();
    check("cfg_s3", signal, 0);
    step();
    check("cfg_done", {done0, busy, signal}, 3'b100);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
